// File: rtl/seq_pattern_tx.sv
// Bit-serial pattern source: shifts a captured pattern out MSB-first, with optional repeats and idle gaps.
// First bit appears one cycle after start; all outputs are registered. There is no backpressure, one bit per clock.
module seq_pattern_tx #(
  parameter int   MAX_LEN  = 8,
  parameter int   LEN_W    = 4,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   pat_len,
  input  logic [CNT_W-1:0]   repeat_cnt,
  input  logic [CNT_W-1:0]   gap_len,
  output logic               o,
  output logic               o_valid,
  output logic               frame_end,
  output logic               busy,
  output logic               done
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state, n_state;
  logic [MAX_LEN-1:0] sh_pat, n_pat;
  logic [LEN_W-1:0]   sh_len, n_len;
  logic [CNT_W-1:0]   sh_gap, n_gap;
  logic [CNT_W-1:0]   frame_cnt, n_frame;
  logic [CNT_W-1:0]   gap_cnt, n_gap_cnt;
  logic [IDX_W-1:0]   bit_idx, n_idx;
  logic [LEN_W-1:0]   len_clamped;
  logic [IDX_W-1:0]   last_idx;

  assign len_clamped = (pat_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : pat_len;
  assign last_idx    = IDX_W'(sh_len - LEN_W'(1));

  always_comb begin
    n_state   = state;
    n_pat     = sh_pat;
    n_len     = sh_len;
    n_gap     = sh_gap;
    n_frame   = frame_cnt;
    n_gap_cnt = gap_cnt;
    n_idx     = bit_idx;
    case (state)
      S_IDLE: begin
        if (start) begin
          n_pat   = pattern;
          n_len   = len_clamped;
          n_gap   = gap_len;
          n_frame = repeat_cnt;
          if (len_clamped == '0) begin
            n_state = S_DONE;
          end else begin
            n_state = S_SEND;
            n_idx   = IDX_W'(len_clamped - LEN_W'(1));
          end
        end
      end
      S_SEND: begin
        if (abort) begin
          n_state = S_IDLE;
        end else if (bit_idx == '0) begin
          if (frame_cnt != '0) begin
            n_frame = frame_cnt - CNT_W'(1);
            if (sh_gap != '0) begin
              n_state   = S_GAP;
              n_gap_cnt = sh_gap;
            end else begin
              n_idx = last_idx;
            end
          end else begin
            n_state = S_DONE;
          end
        end else begin
          n_idx = bit_idx - IDX_W'(1);
        end
      end
      S_GAP: begin
        if (abort) begin
          n_state = S_IDLE;
        end else if (gap_cnt <= CNT_W'(1)) begin
          n_state = S_SEND;
          n_idx   = last_idx;
        end else begin
          n_gap_cnt = gap_cnt - CNT_W'(1);
        end
      end
      default: n_state = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so the first bit lands one cycle after start.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      sh_pat    <= '0;
      sh_len    <= '0;
      sh_gap    <= '0;
      frame_cnt <= '0;
      gap_cnt   <= '0;
      bit_idx   <= '0;
      o         <= IDLE_BIT;
      o_valid   <= 1'b0;
      frame_end <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= n_state;
      sh_pat    <= n_pat;
      sh_len    <= n_len;
      sh_gap    <= n_gap;
      frame_cnt <= n_frame;
      gap_cnt   <= n_gap_cnt;
      bit_idx   <= n_idx;
      o         <= (n_state == S_SEND) ? n_pat[n_idx] : IDLE_BIT;
      o_valid   <= (n_state == S_SEND);
      frame_end <= (n_state == S_SEND) && (n_idx == '0);
      busy      <= (n_state != S_IDLE);
      done      <= (n_state == S_DONE);
    end
  end

endmodule
